keypad_matrix_scan: RTL

//  Scans a 4x4 membrane keypad and produces the debounced 16-bit one-hot key code consumed by the

---
 rtl/keypad_matrix_scan_if.sv | 10 +
 rtl/keypad_matrix_scan.sv | 89 ++++++++
 2 files changed

// File: rtl/keypad_matrix_scan_if.sv
// Keypad-side signal bundle: column strobes out, rows in, debounced key code and event out.
interface keypad_matrix_scan_if;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] onehot;
  logic        key_event;

  modport master (output row, input col, onehot, key_event);
  modport slave  (input row, output col, onehot, key_event);
endinterface

// File: rtl/keypad_matrix_scan.sv
// 4x4 keypad scanner: one-cold column strobes, 2-FF row sync, per-frame ghost rejection
// and N-frame debounce producing a level one-hot key code plus a press event pulse.
module keypad_matrix_scan #(
  parameter int SCAN_DIV        = 50_000,
  parameter int DEBOUNCE_FRAMES = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  keypad_matrix_scan_if.slave  kp
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_FRAMES);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_FRAMES - 1);

  logic [3:0]    r_row_s1, r_row_s2;
  logic [DW-1:0] r_div;
  logic [1:0]    r_col_idx;
  logic [3:0]    r_col;
  logic [15:0]   r_raw;
  logic          r_eval;
  logic [15:0]   r_last_cand;
  logic [CW-1:0] r_stable_cnt;
  logic [15:0]   r_onehot;
  logic          r_key_event;

  logic          w_slot_end, w_frame_end;
  logic [15:0]   w_cand, w_raw_next;
  logic [CW-1:0] w_cnt_next;

  assign w_slot_end  = (r_div == DIV_LAST);
  assign w_frame_end = w_slot_end && (r_col_idx == 2'd3);

  always_comb begin
    // Exactly one key down is a valid code; none or several (ghosting) read as no key.
    w_cand = '0;
    if ((r_raw != 16'h0000) && ((r_raw & (r_raw - 16'd1)) == 16'h0000))
      w_cand = r_raw;

    w_cnt_next = '0;
    if (w_cand == r_last_cand)
      w_cnt_next = (r_stable_cnt == CNT_MAX) ? CNT_MAX : r_stable_cnt + CW'(1);

    w_raw_next = r_eval ? 16'h0000 : r_raw;
    if (w_slot_end)
      for (int r = 0; r < 4; r++)
        w_raw_next[{2'(r), r_col_idx}] = ~r_row_s2[r];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_s1     <= 4'hF;
      r_row_s2     <= 4'hF;
      r_div        <= '0;
      r_col_idx    <= 2'd0;
      r_col        <= 4'b1110;
      r_raw        <= '0;
      r_eval       <= 1'b0;
      r_last_cand  <= '0;
      r_stable_cnt <= '0;
      r_onehot     <= '0;
      r_key_event  <= 1'b0;
    end else begin
      r_row_s1    <= kp.row;
      r_row_s2    <= r_row_s1;
      r_div       <= w_slot_end ? '0 : r_div + DW'(1);
      r_raw       <= w_raw_next;
      r_eval      <= w_frame_end;
      r_key_event <= 1'b0;
      if (w_slot_end) begin
        r_col_idx <= r_col_idx + 2'd1;
        r_col     <= ~(4'b0001 << (r_col_idx + 2'd1));
      end
      if (r_eval) begin
        r_stable_cnt <= w_cnt_next;
        if (w_cand != r_last_cand)
          r_last_cand <= w_cand;
        if ((w_cnt_next == CNT_MAX) && (w_cand != r_onehot)) begin
          r_onehot    <= w_cand;
          r_key_event <= |w_cand;
        end
      end
    end
  end

  assign kp.col       = r_col;
  assign kp.onehot    = r_onehot;
  assign kp.key_event = r_key_event;
endmodule
